// File: rtl/uart_rx_fifo_pkg.sv
// Shared sizing helpers and default thresholds for the UART RX FIFO.
// Imported by the RX top, its RAM and the testbench.
package uart_rx_fifo_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_FIFO_DEPTH    = 16;
    localparam int DEF_AEMPTY_THRESH = 1;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int def_afull(input int depth);
        return depth - 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_ram.sv
// Storage array for the RX FIFO.
// One synchronous write port, one asynchronous read port; contents never reset.
module uart_rx_fifo_ram
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         CLKip,
    input  logic                         i_we,
    input  logic [ptr_w(FIFO_DEPTH)-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]        i_wdata,
    input  logic [ptr_w(FIFO_DEPTH)-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]        o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    // Store the incoming word at the write pointer
    always_ff @(posedge CLKip) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer between the UART byte output and the system consumer.
// Registered-read or fall-through output, thresholds, sticky error flags.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = def_afull(FIFO_DEPTH),
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic                         CLKip,
    input  logic                         RSTi,
    input  logic                         FLUSHi,
    input  logic                         CLRERRi,
    input  logic [DATA_WIDTH-1:0]        DATAi,
    input  logic                         WEi,
    output logic                         FULLo,
    output logic                         AFULLo,
    output logic                         OVFo,
    input  logic                         RDi,
    output logic [DATA_WIDTH-1:0]        DATAo,
    output logic                         EMPTYo,
    output logic                         AEMPTYo,
    output logic                         UDFo,
    output logic [lvl_w(FIFO_DEPTH)-1:0] LEVELo
);

    localparam int PW = ptr_w(FIFO_DEPTH);
    localparam int LW = lvl_w(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || DATA_WIDTH < 1 || (FWFT != 0 && FWFT != 1)
        || AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH
        || AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH - 1)
    begin : g_bad_params
        $error("uart_rx_fifo: illegal parameter combination");
    end

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_ram_we;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == LW'(FIFO_DEPTH));
    assign w_rd_ok  = RDi && !w_empty;
    // A full FIFO still takes a write when the head leaves in the same cycle
    assign w_wr_ok  = WEi && (!w_full || w_rd_ok);
    assign w_ram_we = w_wr_ok && !FLUSHi;

    uart_rx_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_ram (
        .CLKip   (CLKip),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (DATAi),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Pointer and occupancy tracking; flush overrides same-cycle requests
    always_ff @(posedge CLKip or posedge RSTi) begin
        if (RSTi) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (FLUSHi) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_wr_ok && !w_rd_ok)
                r_level <= r_level + LW'(1);
            else if (w_rd_ok && !w_wr_ok)
                r_level <= r_level - LW'(1);
        end
    end

    // Registered read data, used when the output is not fall-through
    always_ff @(posedge CLKip or posedge RSTi) begin
        if (RSTi)
            r_dout <= '0;
        else if (FLUSHi)
            r_dout <= '0;
        else if (w_rd_ok)
            r_dout <= w_rdata;
    end

    // Sticky error flags; a new error in the clearing cycle survives
    always_ff @(posedge CLKip or posedge RSTi) begin
        if (RSTi) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (r_ovf && !CLRERRi) || (!FLUSHi && WEi && !w_wr_ok);
            r_udf <= (r_udf && !CLRERRi) || (!FLUSHi && RDi && w_empty);
        end
    end

    assign FULLo   = w_full;
    assign EMPTYo  = w_empty;
    assign AFULLo  = (r_level >= LW'(AFULL_THRESH));
    assign AEMPTYo = (r_level <= LW'(AEMPTY_THRESH));
    assign OVFo    = r_ovf;
    assign UDFo    = r_udf;
    assign LEVELo  = r_level;
    assign DATAo   = (FWFT != 0) ? (w_empty ? '0 : w_rdata) : r_dout;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: registered-read and fall-through instances side by side,
// queue-based reference model, scoreboard for registered read data.
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    localparam int D  = 16;
    localparam int LW = lvl_w(D);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, flush, clrerr, we, rd;
    logic [7:0] din;

    logic [7:0]    o0_data, o1_data;
    logic [LW-1:0] o0_lvl, o1_lvl;
    logic o0_full, o0_afull, o0_ovf, o0_empty, o0_aempty, o0_udf;
    logic o1_full, o1_afull, o1_ovf, o1_empty, o1_aempty, o1_udf;

    uart_rx_fifo #(.FWFT(0)) dut0 (
        .CLKip(clk), .RSTi(rst), .FLUSHi(flush), .CLRERRi(clrerr),
        .DATAi(din), .WEi(we), .FULLo(o0_full), .AFULLo(o0_afull),
        .OVFo(o0_ovf), .RDi(rd), .DATAo(o0_data), .EMPTYo(o0_empty),
        .AEMPTYo(o0_aempty), .UDFo(o0_udf), .LEVELo(o0_lvl)
    );

    uart_rx_fifo #(.FWFT(1), .AFULL_THRESH(16), .AEMPTY_THRESH(0)) dut1 (
        .CLKip(clk), .RSTi(rst), .FLUSHi(flush), .CLRERRi(clrerr),
        .DATAi(din), .WEi(we), .FULLo(o1_full), .AFULLo(o1_afull),
        .OVFo(o1_ovf), .RDi(rd), .DATAo(o1_data), .EMPTYo(o1_empty),
        .AEMPTYo(o1_aempty), .UDFo(o1_udf), .LEVELo(o1_lvl)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    bit         m_ovf = 0;
    bit         m_udf = 0;
    bit         fire  = 0;
    logic [7:0] hold0 = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        int n;
        n = q.size();
        if (fire) begin
            chk("sb_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) hold0 = exp_q.pop_front();
        end
        chk("d0_data",   32'(o0_data),   32'(hold0));
        chk("d0_level",  32'(o0_lvl),    32'(n));
        chk("d0_empty",  32'(o0_empty),  32'(n == 0));
        chk("d0_full",   32'(o0_full),   32'(n == D));
        chk("d0_afull",  32'(o0_afull),  32'(n >= D - 2));
        chk("d0_aempty", 32'(o0_aempty), 32'(n <= 1));
        chk("d0_ovf",    32'(o0_ovf),    32'(m_ovf));
        chk("d0_udf",    32'(o0_udf),    32'(m_udf));
        chk("d1_data",   32'(o1_data),   (n != 0) ? 32'(q[0]) : 32'd0);
        chk("d1_level",  32'(o1_lvl),    32'(n));
        chk("d1_empty",  32'(o1_empty),  32'(n == 0));
        chk("d1_full",   32'(o1_full),   32'(n == D));
        chk("d1_afull",  32'(o1_afull),  32'(n >= D));
        chk("d1_aempty", 32'(o1_aempty), 32'(n == 0));
        chk("d1_ovf",    32'(o1_ovf),    32'(m_ovf));
        chk("d1_udf",    32'(o1_udf),    32'(m_udf));
    end

    task automatic step(input bit w, input bit r, input logic [7:0] d,
                        input bit f = 0, input bit c = 0);
        bit rok, wok;
        @(negedge clk);
        #1;
        we = w; rd = r; din = d; flush = f; clrerr = c;
        fire = 0;
        rok = 0;
        wok = 0;
        if (f) begin
            q.delete();
            hold0 = 8'h00;
        end else begin
            rok = r && (q.size() > 0);
            wok = w && (q.size() < D || rok);
            if (rok) begin
                exp_q.push_back(q.pop_front());
                fire = 1;
            end
            if (wok) q.push_back(d);
        end
        m_ovf = (m_ovf && !c) || (!f && w && !wok);
        m_udf = (m_udf && !c) || (!f && r && !rok);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        q.delete();
        exp_q.delete();
        m_ovf = 0;
        m_udf = 0;
        fire  = 0;
        hold0 = 8'h00;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_lvl0"},   32'(o0_lvl), 0);
        chk({tag, "_lvl1"},   32'(o1_lvl), 0);
        chk({tag, "_empty"},  32'(o0_empty & o1_empty), 1);
        chk({tag, "_aempty"}, 32'(o0_aempty & o1_aempty), 1);
        chk({tag, "_flags"},  32'({o0_full, o0_afull, o0_ovf, o0_udf,
                                   o1_full, o1_afull, o1_ovf, o1_udf}), 0);
        chk({tag, "_data"},   32'({o0_data, o1_data}), 0);
    endtask

    initial begin
        rst = 1; flush = 0; clrerr = 0; we = 0; rd = 0; din = 0;
        repeat (2) @(negedge clk);
        reset_checks("por");
        @(negedge clk);
        #1 rst = 0;

        for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h11 + i));
        after_edge();
        chk("fill_level", 32'(o0_lvl), 16);
        chk("fill_full",  32'(o0_full), 1);

        step(1, 0, 8'hAA);
        after_edge();
        chk("ovf_set",   32'(o0_ovf), 1);
        chk("ovf_level", 32'(o0_lvl), 16);

        step(1, 1, 8'hAA);
        after_edge();
        chk("wt_level", 32'(o0_lvl), 16);

        step(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 16; i++) step(0, 1, 8'h00);
        step(0, 0, 8'h00);
        chk("drain_last", 32'(o0_data), 32'hAA);
        step(0, 1, 8'h00);
        step(0, 0, 8'h00, 0, 1);

        step(1, 0, 8'h5A);
        after_edge();
        chk("fwft_head", 32'(o1_data), 32'h5A);
        step(0, 1, 8'h00);
        after_edge();
        chk("fwft_empty_data", 32'(o1_data), 0);
        step(0, 1, 8'h00);
        after_edge();
        chk("udf_set", 32'(o1_udf), 1);
        step(0, 0, 8'h00, 0, 1);

        for (int i = 0; i < 3; i++) step(1, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) step(1, 1, 8'($urandom));
        after_edge();
        chk("wrap_level", 32'(o0_lvl), 3);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00);

        for (int i = 0; i < 9; i++) step(1, 0, 8'($urandom));
        step(1, 1, 8'hEE, 1, 0);
        after_edge();
        chk("flush_level", 32'(o0_lvl), 0);
        chk("flush_err",   32'({o0_ovf, o0_udf}), 0);
        step(1, 0, 8'h33);
        step(0, 1, 8'h00);
        step(0, 0, 8'h00);
        chk("post_flush_rd", 32'(o0_data), 32'h33);

        step(0, 1, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 0, 8'($urandom));
        @(negedge clk);
        #1;
        we = 1; rd = 1; din = 8'hC3; flush = 0; clrerr = 0; fire = 0;
        #2 rst = 1;
        #1 reset_checks("mid_rst");
        model_reset();
        @(negedge clk);
        #1 we = 0; rd = 0;
        @(negedge clk);
        #1 rst = 0;
        step(1, 0, 8'h4D);
        step(0, 1, 8'h00);
        step(0, 0, 8'h00);
        chk("post_rst_rd", 32'(o0_data), 32'h4D);

        for (int i = 0; i < 400; i++)
            step(($urandom % 3) != 0, ($urandom % 2) != 0, 8'($urandom),
                 ($urandom % 60) == 0, ($urandom % 25) == 0);
        for (int i = 0; i < 18; i++) step(0, 1, 8'h00);
        repeat (2) step(0, 0, 8'h00, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
